// File: rtl/absorb_sequencer.sv
// ----------------------------------------------------------------------------
// absorb_sequencer
//
// Control sequencer for a sponge-style absorb stage. Accepts a message as a
// stream of beats, presents each beat together with the running byte count
// and the rate to an external absorb datapath, and reacts to its results:
// a full block triggers a permutation, and bytes that overflow the block are
// parked in a carry buffer and absorbed after the permutation completes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i, rate_i       begin a new message; rate (bits) latched on accept
//   t_valid_i/t_ready_o   input stream handshake
//   t_data_i, t_keep_i,   beat data (byte 0 in [7:0]), contiguous byte
//   t_last_i              valids, last-beat marker
//   abs_msg_o, abs_keep_o,
//   abs_rate_o, abs_bytes_o  operands driven to the absorb datapath
//   abs_bytes_i, abs_has_carry_i,
//   abs_carry_i, abs_carry_keep_i  absorb datapath results
//   absorb_en_o           capture strobe for the absorb result
//   perm_start_o/perm_done_i  permutation start / completion pulses
//   done_o, final_bytes_o message absorbed pulse, bytes in the open block
//   busy_o                high whenever not idle
// ----------------------------------------------------------------------------
module absorb_sequencer #(
    parameter int DWIDTH            = 256,
    parameter int KEEP_WIDTH        = 32,
    parameter int RATE_WIDTH        = 11,
    parameter int BYTE_ABSORB_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [RATE_WIDTH-1:0]        rate_i,
    input  logic                         t_valid_i,
    output logic                         t_ready_o,
    input  logic [DWIDTH-1:0]            t_data_i,
    input  logic [KEEP_WIDTH-1:0]        t_keep_i,
    input  logic                         t_last_i,
    output logic [DWIDTH-1:0]            abs_msg_o,
    output logic [KEEP_WIDTH-1:0]        abs_keep_o,
    output logic [RATE_WIDTH-1:0]        abs_rate_o,
    output logic [BYTE_ABSORB_WIDTH-1:0] abs_bytes_o,
    input  logic [BYTE_ABSORB_WIDTH-1:0] abs_bytes_i,
    input  logic                         abs_has_carry_i,
    input  logic [DWIDTH-65:0]           abs_carry_i,
    input  logic [KEEP_WIDTH-9:0]        abs_carry_keep_i,
    output logic                         absorb_en_o,
    output logic                         perm_start_o,
    input  logic                         perm_done_i,
    output logic                         done_o,
    output logic [BYTE_ABSORB_WIDTH-1:0] final_bytes_o,
    output logic                         busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PERMUTE,
        ST_CARRY,
        ST_DONE
    } state_t;

    state_t                       state;
    state_t                       state_next;

    logic [BYTE_ABSORB_WIDTH-1:0] cnt;
    logic [RATE_WIDTH-1:0]        rate_q;
    logic [DWIDTH-65:0]           carry_data;
    logic [KEEP_WIDTH-9:0]        carry_keep;
    logic                         carry_pend;
    logic                         last_pend;
    logic                         perm_issued;
    logic [BYTE_ABSORB_WIDTH-1:0] final_q;

    logic                         handshake;
    logic                         block_full;
    logic [RATE_WIDTH-1:0]        rate_bytes;
    logic [RATE_WIDTH-1:0]        bytes_ext;

    // A beat is consumed only while absorbing; the block is full when the
    // datapath's new count reaches the rate expressed in bytes.
    assign handshake  = (state == ST_ABSORB) && t_valid_i;
    assign rate_bytes = rate_q >> 3;
    assign bytes_ext  = RATE_WIDTH'(abs_bytes_i);
    assign block_full = (bytes_ext == rate_bytes);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Strobes are mutually exclusive by
    // construction since each belongs to a different state.
    always_comb begin
        state_next    = state;
        t_ready_o     = 1'b0;
        absorb_en_o   = 1'b0;
        perm_start_o  = 1'b0;
        done_o        = 1'b0;
        abs_msg_o     = '0;
        abs_keep_o    = '0;
        abs_bytes_o   = '0;
        abs_rate_o    = rate_q;
        final_bytes_o = final_q;
        busy_o        = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_ABSORB;
                end
            end

            ST_ABSORB: begin
                t_ready_o   = 1'b1;
                abs_msg_o   = t_data_i;
                abs_keep_o  = t_keep_i;
                abs_bytes_o = cnt;
                absorb_en_o = handshake;
                if (handshake) begin
                    if (abs_has_carry_i || block_full) begin
                        state_next = ST_PERMUTE;
                    end else if (t_last_i) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_PERMUTE: begin
                perm_start_o = !perm_issued;
                if (perm_done_i) begin
                    if (carry_pend) begin
                        state_next = ST_CARRY;
                    end else if (last_pend) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ABSORB;
                    end
                end
            end

            ST_CARRY: begin
                // Carried bytes restart a fresh block at offset zero; they
                // can never overflow again as they are fewer than any rate.
                abs_msg_o   = {64'b0, carry_data};
                abs_keep_o  = {8'b0, carry_keep};
                abs_bytes_o = '0;
                absorb_en_o = 1'b1;
                state_next  = last_pend ? ST_DONE : ST_ABSORB;
            end

            ST_DONE: begin
                done_o        = 1'b1;
                final_bytes_o = cnt;
                state_next    = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Message bookkeeping: byte count, latched rate, carry buffer and the
    // pending flags that steer the exit from PERMUTE and CARRY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rate_q      <= '0;
            carry_data  <= '0;
            carry_keep  <= '0;
            carry_pend  <= 1'b0;
            last_pend   <= 1'b0;
            perm_issued <= 1'b0;
            final_q     <= '0;
        end else begin
            // perm_start_o fires only in the first PERMUTE cycle.
            perm_issued <= (state == ST_PERMUTE);

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        rate_q     <= rate_i;
                        cnt        <= '0;
                        carry_pend <= 1'b0;
                        last_pend  <= 1'b0;
                        final_q    <= '0;
                    end
                end

                ST_ABSORB: begin
                    if (handshake) begin
                        cnt       <= abs_bytes_i;
                        last_pend <= t_last_i;
                        if (abs_has_carry_i) begin
                            carry_data <= abs_carry_i;
                            carry_keep <= abs_carry_keep_i;
                            carry_pend <= 1'b1;
                        end
                    end
                end

                ST_PERMUTE: begin
                    if (perm_done_i) begin
                        cnt <= '0;
                    end
                end

                ST_CARRY: begin
                    cnt        <= abs_bytes_i;
                    carry_pend <= 1'b0;
                end

                ST_DONE: begin
                    // Keep the reported count visible after the pulse.
                    final_q <= cnt;
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_absorb_sequencer.sv
// ----------------------------------------------------------------------------
// tb_absorb_sequencer
//
// Directed bench for absorb_sequencer. A small behavioural absorb datapath
// answers the sequencer's operands (count plus valid bytes, clipped at the
// rate with the overflow returned as a carry). Stimulus is applied on the
// falling edge and outputs are checked shortly afterwards.
// ----------------------------------------------------------------------------
module tb_absorb_sequencer;

    localparam int DW  = 256;
    localparam int KW  = 32;
    localparam int RW  = 11;
    localparam int BW  = 8;
    localparam logic [KW-1:0] ALL_KEEP = '1;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [RW-1:0] rate_i;
    logic          t_valid_i;
    logic          t_ready_o;
    logic [DW-1:0] t_data_i;
    logic [KW-1:0] t_keep_i;
    logic          t_last_i;
    logic [DW-1:0] abs_msg_o;
    logic [KW-1:0] abs_keep_o;
    logic [RW-1:0] abs_rate_o;
    logic [BW-1:0] abs_bytes_o;
    logic [BW-1:0] abs_bytes_i;
    logic          abs_has_carry_i;
    logic [DW-65:0] abs_carry_i;
    logic [KW-9:0] abs_carry_keep_i;
    logic          absorb_en_o;
    logic          perm_start_o;
    logic          perm_done_i;
    logic          done_o;
    logic [BW-1:0] final_bytes_o;
    logic          busy_o;

    int compared;
    int mismatched;
    int perm_count;
    int perm_base;

    int m_total;
    int m_rb;
    int m_taken;

    logic [DW-1:0] beat [5];

    absorb_sequencer #(
        .DWIDTH(DW), .KEEP_WIDTH(KW), .RATE_WIDTH(RW), .BYTE_ABSORB_WIDTH(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .rate_i(rate_i),
        .t_valid_i(t_valid_i), .t_ready_o(t_ready_o), .t_data_i(t_data_i),
        .t_keep_i(t_keep_i), .t_last_i(t_last_i), .abs_msg_o(abs_msg_o),
        .abs_keep_o(abs_keep_o), .abs_rate_o(abs_rate_o),
        .abs_bytes_o(abs_bytes_o), .abs_bytes_i(abs_bytes_i),
        .abs_has_carry_i(abs_has_carry_i), .abs_carry_i(abs_carry_i),
        .abs_carry_keep_i(abs_carry_keep_i), .absorb_en_o(absorb_en_o),
        .perm_start_o(perm_start_o), .perm_done_i(perm_done_i),
        .done_o(done_o), .final_bytes_o(final_bytes_o), .busy_o(busy_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural absorb datapath: add the valid bytes to the running count,
    // clip at the rate and hand back whatever did not fit as a carry.
    always_comb begin
        m_rb    = int'(abs_rate_o) / 8;
        m_total = int'(abs_bytes_o) + $countones(abs_keep_o);
        m_taken = 0;
        abs_has_carry_i = 1'b0;
        abs_bytes_i     = BW'(m_total);
        if (m_total > m_rb) begin
            abs_has_carry_i = 1'b1;
            abs_bytes_i     = BW'(m_rb);
            m_taken         = m_rb - int'(abs_bytes_o);
        end
        abs_carry_i      = (DW-64)'(abs_msg_o >> (8 * m_taken));
        abs_carry_keep_i = (KW-8)'(abs_keep_o >> m_taken);
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic st, input logic [RW-1:0] rate,
                                 input logic vld, input logic [DW-1:0] data,
                                 input logic [KW-1:0] keep, input logic last,
                                 input logic pdone);
        @(negedge clk);
        start_i     = st;
        rate_i      = rate;
        t_valid_i   = vld;
        t_data_i    = data;
        t_keep_i    = keep;
        t_last_i    = last;
        perm_done_i = pdone;
        #1;
    endtask

    // Count permutation starts and watch that the three strobes never overlap.
    always @(posedge clk) begin
        if (perm_start_o) begin
            perm_count++;
        end
        if (rst_n) begin
            checkOutput("strobe_excl",
                        DW'($countones({absorb_en_o, perm_start_o, done_o}) > 1), '0);
        end
    end

    initial begin
        compared    = 0;
        mismatched  = 0;
        perm_count  = 0;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        rate_i      = '0;
        t_valid_i   = 1'b1;
        t_data_i    = '0;
        t_keep_i    = ALL_KEEP;
        t_last_i    = 1'b0;
        perm_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat[i] = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
        end

        // Reset state, with a valid beat already offered.
        #3;
        checkOutput("rst_ready", DW'(t_ready_o), 0);
        checkOutput("rst_busy", DW'(busy_o), 0);
        checkOutput("rst_done", DW'(done_o), 0);
        checkOutput("rst_absorb_en", DW'(absorb_en_o), 0);
        checkOutput("rst_perm_start", DW'(perm_start_o), 0);
        checkOutput("rst_final", DW'(final_bytes_o), 0);
        t_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Rate 1088 (136 bytes): four full beats, the fifth overflows by 24.
        $display("[TB] rate 1088 carry message");
        perm_base = perm_count;
        applyStimulus(1, 11'd1088, 0, '0, '0, 0, 0);
        checkOutput("idle_busy", DW'(busy_o), 0);
        checkOutput("idle_ready", DW'(t_ready_o), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 11'd1088, 1, beat[i], ALL_KEEP, 0, 0);
            checkOutput("r1088_cnt", DW'(abs_bytes_o), DW'(32 * i));
            checkOutput("r1088_absorb_en", DW'(absorb_en_o), 1);
            checkOutput("r1088_ready", DW'(t_ready_o), 1);
        end
        checkOutput("r1088_rate", DW'(abs_rate_o), 1088);
        applyStimulus(0, 11'd1088, 1, beat[0], ALL_KEEP, 0, 0);
        checkOutput("perm_start_first", DW'(perm_start_o), 1);
        checkOutput("perm_ready", DW'(t_ready_o), 0);
        checkOutput("perm_absorb_en", DW'(absorb_en_o), 0);
        applyStimulus(0, 11'd1088, 0, '0, '0, 0, 0);
        checkOutput("perm_start_second", DW'(perm_start_o), 0);
        applyStimulus(0, 11'd1088, 0, '0, '0, 0, 1);
        checkOutput("perm_busy", DW'(busy_o), 1);
        applyStimulus(0, 11'd1088, 0, '0, '0, 0, 0);
        checkOutput("carry_absorb_en", DW'(absorb_en_o), 1);
        checkOutput("carry_bytes", DW'(abs_bytes_o), 0);
        checkOutput("carry_msg", abs_msg_o, beat[4] >> 64);
        checkOutput("carry_keep", DW'(abs_keep_o), 32'h00FF_FFFF);
        checkOutput("carry_ready", DW'(t_ready_o), 0);
        applyStimulus(0, 11'd1088, 0, '0, '0, 0, 0);
        checkOutput("after_carry_cnt", DW'(abs_bytes_o), 24);
        checkOutput("after_carry_ready", DW'(t_ready_o), 1);
        checkOutput("r1088_perm_count", DW'(perm_count - perm_base), 1);
        applyStimulus(0, 11'd1088, 1, '0, '0, 1, 0);
        checkOutput("empty_last_absorb_en", DW'(absorb_en_o), 1);
        applyStimulus(0, 11'd1088, 0, '0, '0, 0, 0);
        checkOutput("r1088_done", DW'(done_o), 1);
        checkOutput("r1088_final", DW'(final_bytes_o), 24);
        applyStimulus(0, 11'd1088, 0, '0, '0, 0, 0);
        checkOutput("r1088_done_pulse", DW'(done_o), 0);
        checkOutput("r1088_final_hold", DW'(final_bytes_o), 24);
        checkOutput("r1088_idle_busy", DW'(busy_o), 0);

        // Rate 576 (72 bytes): last beat exactly fills the block.
        $display("[TB] rate 576 exact fill");
        applyStimulus(1, 11'd576, 0, '0, '0, 0, 0);
        applyStimulus(0, 11'd576, 1, beat[1], ALL_KEEP, 0, 0);
        applyStimulus(0, 11'd576, 1, beat[2], ALL_KEEP, 0, 0);
        applyStimulus(0, 11'd576, 1, beat[3], 32'h0000_00FF, 1, 0);
        checkOutput("r576_cnt", DW'(abs_bytes_o), 64);
        applyStimulus(0, 11'd576, 0, '0, '0, 0, 0);
        checkOutput("r576_perm_start", DW'(perm_start_o), 1);
        applyStimulus(0, 11'd576, 0, '0, '0, 0, 1);
        applyStimulus(0, 11'd576, 0, '0, '0, 0, 0);
        checkOutput("r576_done", DW'(done_o), 1);
        checkOutput("r576_final", DW'(final_bytes_o), 0);

        // Single empty last beat: done two cycles after start, no permutation.
        $display("[TB] empty message");
        applyStimulus(0, 11'd576, 0, '0, '0, 0, 0);
        perm_base = perm_count;
        applyStimulus(1, 11'd1152, 0, '0, '0, 0, 0);
        applyStimulus(0, 11'd1152, 1, '0, '0, 1, 0);
        checkOutput("empty_absorb_en", DW'(absorb_en_o), 1);
        checkOutput("empty_cnt", DW'(abs_bytes_o), 0);
        applyStimulus(0, 11'd1152, 0, '0, '0, 0, 0);
        checkOutput("empty_done", DW'(done_o), 1);
        checkOutput("empty_final", DW'(final_bytes_o), 0);
        applyStimulus(0, 11'd1152, 0, '0, '0, 0, 0);
        checkOutput("empty_idle", DW'(busy_o), 0);
        checkOutput("empty_no_perm", DW'(perm_count - perm_base), 0);

        // Long permutation with valid held: no beat may be taken.
        $display("[TB] stalled permutation");
        applyStimulus(1, 11'd576, 0, '0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 11'd576, 1, beat[i], ALL_KEEP, 0, 0);
        end
        for (int i = 0; i < 24; i++) begin
            applyStimulus(0, 11'd576, 1, beat[1], ALL_KEEP, 0, 0);
            checkOutput("stall_ready", DW'(t_ready_o), 0);
            checkOutput("stall_absorb_en", DW'(absorb_en_o), 0);
            checkOutput("stall_perm_start", DW'(perm_start_o), DW'(i == 0));
        end

        // Reset in PERMUTE with a carry pending discards the message.
        $display("[TB] reset mid-permutation");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", DW'(busy_o), 0);
        checkOutput("midrst_ready", DW'(t_ready_o), 0);
        checkOutput("midrst_absorb_en", DW'(absorb_en_o), 0);
        checkOutput("midrst_perm_start", DW'(perm_start_o), 0);
        checkOutput("midrst_rate", DW'(abs_rate_o), 0);
        t_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 11'd0, 0, '0, '0, 0, 1);
        checkOutput("release_done", DW'(done_o), 0);
        checkOutput("release_perm_start", DW'(perm_start_o), 0);
        checkOutput("release_busy", DW'(busy_o), 0);
        applyStimulus(1, 11'd1344, 0, '0, '0, 0, 0);
        applyStimulus(0, 11'd1344, 1, beat[2], ALL_KEEP, 0, 0);
        checkOutput("r1344_cnt", DW'(abs_bytes_o), 0);
        checkOutput("r1344_rate", DW'(abs_rate_o), 1344);
        checkOutput("r1344_absorb_en", DW'(absorb_en_o), 1);

        // start_i while absorbing is ignored; rate stays 1344.
        $display("[TB] start ignored while busy");
        applyStimulus(1, 11'd832, 0, '0, '0, 0, 0);
        checkOutput("ign_busy", DW'(busy_o), 1);
        applyStimulus(0, 11'd832, 0, '0, '0, 0, 0);
        checkOutput("ign_rate", DW'(abs_rate_o), 1344);
        checkOutput("ign_cnt", DW'(abs_bytes_o), 32);
        applyStimulus(0, 11'd832, 1, beat[3], 32'h0000_000F, 1, 0);
        checkOutput("ign_last_absorb_en", DW'(absorb_en_o), 1);
        applyStimulus(0, 11'd832, 0, '0, '0, 0, 0);
        checkOutput("ign_done", DW'(done_o), 1);
        checkOutput("ign_final", DW'(final_bytes_o), 36);
        applyStimulus(0, 11'd832, 0, '0, '0, 0, 0);
        checkOutput("ign_idle", DW'(busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
